// File: rtl/stitch_mem_scheduler_if.sv
// Command channel between the stitch memory scheduler and the AXI burst engine.
interface stitch_mem_scheduler_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_wr;
    logic [1:0]            cmd_id;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic                  cmd_done;

    modport master (
        output cmd_valid, cmd_wr, cmd_id, cmd_addr,
        input  cmd_ready, cmd_done
    );

    modport slave (
        input  cmd_valid, cmd_wr, cmd_id, cmd_addr,
        output cmd_ready, cmd_done
    );
endinterface

// File: rtl/stitch_mem_scheduler.sv
// Shares one AXI burst master between three camera write streams and one stitched read stream,
// generating per-channel burst addresses for the cam0 | cam1/cam2 stitched frame layout.
module stitch_mem_scheduler #(
    parameter logic [31:0] C_M_TARGET_SLAVE_BASE_ADDR = 32'h1000_0000,
    parameter int unsigned C_M_AXI_ADDR_WIDTH         = 32,
    parameter int unsigned C_M_AXI_DATA_WIDTH         = 128,
    parameter int unsigned C_M_AXI_BURST_LEN          = 16,
    parameter logic [31:0] CH_STRIDE                  = 32'h0100_0000,
    parameter int unsigned IMG0_HDISP                 = 1920,
    parameter int unsigned IMG0_VDISP                 = 1080,
    parameter int unsigned IMG1_HDISP                 = 960,
    parameter int unsigned IMG1_VDISP                 = 540
) (
    input  logic       M_AXI_ACLK,
    input  logic       M_AXI_ARESETN,
    input  logic [2:0] wr_req,
    input  logic [2:0] wr_frame_start,
    output logic [2:0] wr_grant,
    input  logic       rd_req,
    input  logic       rd_urgent,
    input  logic       rd_frame_start,
    output logic       rd_grant,
    stitch_mem_scheduler_if.master cmd
);

    localparam int unsigned AW          = C_M_AXI_ADDR_WIDTH;
    localparam int unsigned BURST_BYTES = C_M_AXI_BURST_LEN * C_M_AXI_DATA_WIDTH / 8;
    localparam int unsigned PPB         = C_M_AXI_BURST_LEN * C_M_AXI_DATA_WIDTH / 32;
    localparam int unsigned FB0         = IMG0_HDISP * IMG0_VDISP / PPB;
    localparam int unsigned FB1         = IMG1_HDISP * IMG1_VDISP / PPB;
    localparam int unsigned FB_MAX      = (FB0 > FB1) ? FB0 : FB1;
    localparam int unsigned SEG_L       = IMG0_HDISP / PPB;
    localparam int unsigned SEG_R       = IMG1_HDISP / PPB;
    localparam int unsigned CNT_W       = (FB_MAX > 1) ? $clog2(FB_MAX) : 1;
    localparam int unsigned LINE_W      = (IMG0_VDISP > 1) ? $clog2(IMG0_VDISP) : 1;
    localparam int unsigned SEG_W       = ((SEG_L + SEG_R) > 1) ? $clog2(SEG_L + SEG_R) : 1;

    localparam logic [AW-1:0] BASE0 = AW'(C_M_TARGET_SLAVE_BASE_ADDR);
    localparam logic [AW-1:0] BASE1 = BASE0 + AW'(CH_STRIDE);
    localparam logic [AW-1:0] BASE2 = BASE1 + AW'(CH_STRIDE);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_issue;
    logic              w_accept;
    logic              w_done;

    logic              r_cmd_valid;
    logic              r_cmd_wr;
    logic [1:0]        r_cmd_id;
    logic [AW-1:0]     r_cmd_addr;
    logic [2:0]        r_wr_grant;
    logic              r_rd_grant;
    logic [1:0]        r_last_id;

    logic [CNT_W-1:0]  r_wcnt [3];
    logic [2:0]        r_wpend;
    logic [CNT_W-1:0]  r_rd_p0;
    logic [CNT_W-1:0]  r_rd_pr;
    logic [SEG_W-1:0]  r_rd_x;
    logic [LINE_W-1:0] r_rd_y;
    logic              r_rd_pend;

    logic [3:0]        w_req;
    logic              w_any_req;
    logic [1:0]        w_rr_idx;
    logic [1:0]        w_rr_id;
    logic              w_rr_found;
    logic [1:0]        w_sel_id;
    logic [AW-1:0]     w_sel_addr;
    logic [CNT_W-1:0]  w_wcnt_eff [3];
    logic [CNT_W-1:0]  w_p0_eff;
    logic [CNT_W-1:0]  w_pr_eff;
    logic [SEG_W-1:0]  w_x_eff;
    logic [LINE_W-1:0] w_y_eff;

    assign w_req     = {rd_req, wr_req};
    assign w_any_req = |w_req;

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_accept    = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_issue     = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (cmd.cmd_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (cmd.cmd_done) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Round-robin search starts one past the last grant; k == 4 revisits the last grant itself.
    always_comb begin
        w_rr_idx   = '0;
        w_rr_id    = '0;
        w_rr_found = 1'b0;
        for (int unsigned k = 1; k <= 4; k++) begin
            w_rr_idx = r_last_id + 2'(k);
            if (!w_rr_found && w_req[w_rr_idx]) begin
                w_rr_found = 1'b1;
                w_rr_id    = w_rr_idx;
            end
        end
        w_sel_id = (rd_req && rd_urgent) ? 2'd3 : w_rr_id;
    end

    // A frame_start arriving in the arbitration cycle already applies to the burst being issued.
    always_comb begin
        for (int unsigned i = 0; i < 3; i++) begin
            w_wcnt_eff[i] = wr_frame_start[i] ? '0 : r_wcnt[i];
        end
        w_p0_eff   = rd_frame_start ? '0 : r_rd_p0;
        w_pr_eff   = rd_frame_start ? '0 : r_rd_pr;
        w_x_eff    = rd_frame_start ? '0 : r_rd_x;
        w_y_eff    = rd_frame_start ? '0 : r_rd_y;
        w_sel_addr = '0;
        case (w_sel_id)
            2'd0: w_sel_addr = BASE0 + AW'(w_wcnt_eff[0]) * AW'(BURST_BYTES);
            2'd1: w_sel_addr = BASE1 + AW'(w_wcnt_eff[1]) * AW'(BURST_BYTES);
            2'd2: w_sel_addr = BASE2 + AW'(w_wcnt_eff[2]) * AW'(BURST_BYTES);
            default: begin
                if (w_x_eff < SEG_W'(SEG_L)) begin
                    w_sel_addr = BASE0 + AW'(w_p0_eff) * AW'(BURST_BYTES);
                end else if (w_y_eff < LINE_W'(IMG1_VDISP)) begin
                    w_sel_addr = BASE1 + AW'(w_pr_eff) * AW'(BURST_BYTES);
                end else begin
                    w_sel_addr = BASE2 + AW'(w_pr_eff) * AW'(BURST_BYTES);
                end
            end
        endcase
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            r_cmd_valid <= 1'b0;
            r_cmd_wr    <= 1'b0;
            r_cmd_id    <= '0;
            r_cmd_addr  <= '0;
            r_wr_grant  <= '0;
            r_rd_grant  <= 1'b0;
            r_last_id   <= 2'd3;
        end else begin
            if (w_issue) begin
                r_cmd_valid <= 1'b1;
                r_cmd_wr    <= (w_sel_id != 2'd3);
                r_cmd_id    <= w_sel_id;
                r_cmd_addr  <= w_sel_addr;
                r_wr_grant  <= (w_sel_id == 2'd3) ? 3'b000 : (3'b001 << w_sel_id);
                r_rd_grant  <= (w_sel_id == 2'd3);
                r_last_id   <= w_sel_id;
            end
            if (w_accept) begin
                r_cmd_valid <= 1'b0;
            end
            if (w_done) begin
                r_wr_grant <= '0;
                r_rd_grant <= 1'b0;
            end
        end
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            for (int unsigned i = 0; i < 3; i++) begin
                r_wcnt[i] <= '0;
            end
            r_wpend <= '0;
        end else begin
            for (int unsigned i = 0; i < 3; i++) begin
                if (w_done && r_wr_grant[i]) begin
                    r_wpend[i] <= 1'b0;
                    if (wr_frame_start[i] || r_wpend[i]) begin
                        r_wcnt[i] <= '0;
                    end else if (r_wcnt[i] == ((i == 0) ? CNT_W'(FB0 - 1) : CNT_W'(FB1 - 1))) begin
                        r_wcnt[i] <= '0;
                    end else begin
                        r_wcnt[i] <= r_wcnt[i] + CNT_W'(1);
                    end
                end else if (wr_frame_start[i]) begin
                    if (r_wr_grant[i]) begin
                        r_wpend[i] <= 1'b1;
                    end else begin
                        r_wcnt[i] <= '0;
                    end
                end
            end
        end
    end

    // Read walk: SEG_L left bursts then SEG_R right bursts per line; pr restarts at the cam1->cam2 seam.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            r_rd_p0   <= '0;
            r_rd_pr   <= '0;
            r_rd_x    <= '0;
            r_rd_y    <= '0;
            r_rd_pend <= 1'b0;
        end else if (w_done && r_rd_grant) begin
            r_rd_pend <= 1'b0;
            if (rd_frame_start || r_rd_pend) begin
                r_rd_p0 <= '0;
                r_rd_pr <= '0;
                r_rd_x  <= '0;
                r_rd_y  <= '0;
            end else begin
                if (r_rd_x < SEG_W'(SEG_L)) begin
                    r_rd_p0 <= r_rd_p0 + CNT_W'(1);
                end else begin
                    r_rd_pr <= r_rd_pr + CNT_W'(1);
                end
                if (r_rd_x == SEG_W'(SEG_L + SEG_R - 1)) begin
                    r_rd_x <= '0;
                    if (r_rd_y == LINE_W'(IMG0_VDISP - 1)) begin
                        r_rd_y  <= '0;
                        r_rd_p0 <= '0;
                        r_rd_pr <= '0;
                    end else begin
                        r_rd_y <= r_rd_y + LINE_W'(1);
                        if (r_rd_y == LINE_W'(IMG1_VDISP - 1)) begin
                            r_rd_pr <= '0;
                        end
                    end
                end else begin
                    r_rd_x <= r_rd_x + SEG_W'(1);
                end
            end
        end else if (rd_frame_start) begin
            if (r_rd_grant) begin
                r_rd_pend <= 1'b1;
            end else begin
                r_rd_p0 <= '0;
                r_rd_pr <= '0;
                r_rd_x  <= '0;
                r_rd_y  <= '0;
            end
        end
    end

    assign cmd.cmd_valid = r_cmd_valid;
    assign cmd.cmd_wr    = r_cmd_wr;
    assign cmd.cmd_id    = r_cmd_id;
    assign cmd.cmd_addr  = r_cmd_addr;
    assign wr_grant      = r_wr_grant;
    assign rd_grant      = r_rd_grant;

endmodule

// File: tb/tb_stitch_mem_scheduler.sv
// Scoreboard bench for stitch_mem_scheduler on a reduced frame geometry so frame wraps are reachable.
module tb_stitch_mem_scheduler;

    localparam int unsigned AW     = 32;
    localparam int unsigned H0     = 256;
    localparam int unsigned V0     = 8;
    localparam int unsigned H1     = 128;
    localparam int unsigned V1     = 4;
    localparam int unsigned PPB    = 64;
    localparam int unsigned BB     = 256;
    localparam int unsigned FB0    = H0 * V0 / PPB;
    localparam int unsigned FB1    = H1 * V1 / PPB;
    localparam int unsigned NL     = H0 / PPB;
    localparam int unsigned NR     = H1 / PPB;
    localparam int unsigned RB     = V0 * (NL + NR);
    localparam logic [31:0] BASE   = 32'h1000_0000;
    localparam logic [31:0] STRIDE = 32'h0100_0000;

    typedef struct packed {
        logic [1:0]  id;
        logic        wr;
        logic [31:0] addr;
    } exp_t;

    logic       clk            = 1'b0;
    logic       rst_n          = 1'b0;
    logic [2:0] wr_req         = '0;
    logic [2:0] wr_frame_start = '0;
    logic [2:0] wr_grant;
    logic       rd_req         = 1'b0;
    logic       rd_urgent      = 1'b0;
    logic       rd_frame_start = 1'b0;
    logic       rd_grant;

    always #5 clk = ~clk;

    stitch_mem_scheduler_if #(.ADDR_WIDTH(AW)) bus ();

    stitch_mem_scheduler #(
        .C_M_TARGET_SLAVE_BASE_ADDR(BASE),
        .C_M_AXI_ADDR_WIDTH(AW),
        .C_M_AXI_DATA_WIDTH(128),
        .C_M_AXI_BURST_LEN(16),
        .CH_STRIDE(STRIDE),
        .IMG0_HDISP(H0),
        .IMG0_VDISP(V0),
        .IMG1_HDISP(H1),
        .IMG1_VDISP(V1)
    ) dut (
        .M_AXI_ACLK(clk),
        .M_AXI_ARESETN(rst_n),
        .wr_req(wr_req),
        .wr_frame_start(wr_frame_start),
        .wr_grant(wr_grant),
        .rd_req(rd_req),
        .rd_urgent(rd_urgent),
        .rd_frame_start(rd_frame_start),
        .rd_grant(rd_grant),
        .cmd(bus.master)
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    exp_t        q[$];
    int unsigned m_wcnt [3];
    int unsigned m_rcnt;
    int unsigned m_last;

    // Reference model: burst counts per channel, addresses derived from the frame geometry.
    function automatic logic [31:0] model_addr(input int unsigned id);
        int unsigned line;
        int unsigned x;
        if (id < 3) return BASE + id * STRIDE + m_wcnt[id] * BB;
        line = m_rcnt / (NL + NR);
        x    = m_rcnt % (NL + NR);
        if (x < NL) return BASE + (line * NL + x) * BB;
        if (line < V1) return BASE + STRIDE + (line * NR + x - NL) * BB;
        return BASE + 2 * STRIDE + ((line - V1) * NR + x - NL) * BB;
    endfunction

    function automatic int unsigned model_arb(input logic [2:0] wr, input logic rd, input logic urg);
        logic [3:0] req;
        req = {rd, wr};
        if (rd && urg) return 3;
        for (int unsigned k = 1; k <= 4; k++) begin
            if (req[(m_last + k) % 4]) return (m_last + k) % 4;
        end
        return 0;
    endfunction

    function automatic void model_clear(input logic [3:0] f);
        for (int unsigned c = 0; c < 3; c++) begin
            if (f[c]) m_wcnt[c] = 0;
        end
        if (f[3]) m_rcnt = 0;
    endfunction

    function automatic void model_reset();
        for (int unsigned c = 0; c < 3; c++) m_wcnt[c] = 0;
        m_rcnt = 0;
        m_last = 3;
    endfunction

    task automatic drive_fs(input logic [3:0] f);
        wr_frame_start = f[2:0];
        rd_frame_start = f[3];
    endtask

    task automatic check_outs_zero(input string name);
        n_tests++;
        if (bus.cmd_valid !== 1'b0 || bus.cmd_wr !== 1'b0 || bus.cmd_id !== 2'd0 ||
            bus.cmd_addr !== 32'h0 || wr_grant !== 3'b000 || rd_grant !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: valid=%0b wr=%0b id=%0d addr=%h wr_grant=%b rd_grant=%0b, required all zero",
                     name, bus.cmd_valid, bus.cmd_wr, bus.cmd_id, bus.cmd_addr, wr_grant, rd_grant);
        end
    endtask

    // One scheduled burst: fs_when 0 = frame_start in the arbitration cycle, 1 = during WAIT_DONE,
    // 2 = coincident with cmd_done.
    task automatic do_txn(input logic [2:0] wr, input logic rd, input logic urg,
                          input int unsigned rdy_dly, input int unsigned done_dly,
                          input logic [3:0] fs, input int unsigned fs_when, input bit spurious);
        int unsigned id;
        int unsigned cyc;
        exp_t        e;
        wr_req    = wr;
        rd_req    = rd;
        rd_urgent = urg;
        if (fs_when == 0) begin
            drive_fs(fs);
            model_clear(fs);
        end
        id     = model_arb(wr, rd, urg);
        e.id   = 2'(id);
        e.wr   = (id != 3);
        e.addr = model_addr(id);
        q.push_back(e);
        m_last = id;
        cyc    = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
            drive_fs(4'b0000);
        end while (!bus.cmd_valid && cyc < 8);
        wr_req    = '0;
        rd_req    = 1'b0;
        rd_urgent = 1'b0;
        if (!bus.cmd_valid) begin
            n_tests++;
            n_fail++;
            $display("FAIL issue_timeout: cmd_valid=0 after %0d cycles, required 1", cyc);
            return;
        end
        if (spurious) begin
            bus.cmd_done = 1'b1;
            @(posedge clk); #1;
            bus.cmd_done = 1'b0;
        end
        repeat (rdy_dly) begin @(posedge clk); #1; end
        bus.cmd_ready = 1'b1;
        @(posedge clk); #1;
        bus.cmd_ready = 1'b0;
        if (fs_when == 1) begin
            drive_fs(fs);
            @(posedge clk); #1;
            drive_fs(4'b0000);
        end
        repeat (done_dly) begin @(posedge clk); #1; end
        bus.cmd_done = 1'b1;
        if (fs_when == 2) drive_fs(fs);
        @(posedge clk); #1;
        bus.cmd_done = 1'b0;
        drive_fs(4'b0000);
        if (id < 3) m_wcnt[id] = (m_wcnt[id] + 1) % ((id == 0) ? FB0 : FB1);
        else        m_rcnt     = (m_rcnt + 1) % RB;
        if (fs_when != 0) model_clear(fs);
    endtask

    // Monitor: compares every accepted command against the scoreboard and checks stall stability.
    logic        p_valid = 1'b0;
    logic        p_ready = 1'b0;
    logic        p_wr    = 1'b0;
    logic [1:0]  p_id    = '0;
    logic [31:0] p_addr  = '0;
    logic [2:0]  p_wg    = '0;
    logic        p_rg    = 1'b0;

    always @(negedge clk) begin
        exp_t       e;
        logic [2:0] eg;
        if (!rst_n) begin
            p_valid = 1'b0;
        end else begin
            if (p_valid && !p_ready) begin
                n_tests++;
                if (bus.cmd_valid !== 1'b1 || bus.cmd_addr !== p_addr || bus.cmd_id !== p_id ||
                    bus.cmd_wr !== p_wr || wr_grant !== p_wg || rd_grant !== p_rg) begin
                    n_fail++;
                    $display("FAIL stall_hold: valid=%0b id=%0d addr=%h grants=%b/%0b, required valid=1 id=%0d addr=%h grants=%b/%0b",
                             bus.cmd_valid, bus.cmd_id, bus.cmd_addr, wr_grant, rd_grant, p_id, p_addr, p_wg, p_rg);
                end
            end
            if (bus.cmd_valid && bus.cmd_ready) begin
                if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_cmd: id=%0d addr=%h, required no command", bus.cmd_id, bus.cmd_addr);
                end else begin
                    e  = q.pop_front();
                    eg = (e.id == 2'd3) ? 3'b000 : 3'(3'b001 << e.id);
                    n_tests++;
                    if (bus.cmd_id !== e.id) begin
                        n_fail++;
                        $display("FAIL cmd_id: got %0d, required %0d", bus.cmd_id, e.id);
                    end
                    n_tests++;
                    if (bus.cmd_addr !== e.addr) begin
                        n_fail++;
                        $display("FAIL cmd_addr: id=%0d got %h, required %h", e.id, bus.cmd_addr, e.addr);
                    end
                    n_tests++;
                    if (bus.cmd_wr !== e.wr) begin
                        n_fail++;
                        $display("FAIL cmd_wr: got %0b, required %0b", bus.cmd_wr, e.wr);
                    end
                    n_tests++;
                    if (wr_grant !== eg || rd_grant !== (e.id == 2'd3)) begin
                        n_fail++;
                        $display("FAIL grant: got wr=%b rd=%0b, required wr=%b rd=%0b",
                                 wr_grant, rd_grant, eg, (e.id == 2'd3));
                    end
                end
            end
            p_valid = bus.cmd_valid;
            p_ready = bus.cmd_ready;
            p_wr    = bus.cmd_wr;
            p_id    = bus.cmd_id;
            p_addr  = bus.cmd_addr;
            p_wg    = wr_grant;
            p_rg    = rd_grant;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned cyc;
        exp_t        e;
        bus.cmd_ready = 1'b0;
        bus.cmd_done  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outs_zero("reset_state");
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) do_txn(3'b111, 1'b1, 1'b0, 0, 4, 4'b0000, 0, 1'b0);

        for (int i = 0; i < 3; i++) do_txn(3'b111, 1'b1, 1'b1, 0, 4, 4'b0000, 0, 1'b0);
        for (int i = 0; i < 2; i++) do_txn(3'b111, 1'b1, 1'b0, 0, 4, 4'b0000, 0, 1'b0);

        for (int i = 0; i < int'(FB0) + 2; i++) do_txn(3'b001, 1'b0, 1'b0, 0, 0, 4'b0000, 0, 1'b0);
        do_txn(3'b001, 1'b0, 1'b0, 0, 0, 4'b0001, 0, 1'b0);
        do_txn(3'b001, 1'b0, 1'b0, 0, 0, 4'b0000, 0, 1'b0);

        for (int i = 0; i < int'(RB) + 3; i++) do_txn(3'b000, 1'b1, 1'b0, 0, 0, 4'b0000, 0, 1'b0);

        do_txn(3'b010, 1'b0, 1'b0, 10, 2, 4'b0000, 0, 1'b0);
        do_txn(3'b010, 1'b0, 1'b0, 0, 3, 4'b0010, 1, 1'b0);
        do_txn(3'b010, 1'b0, 1'b0, 0, 1, 4'b0000, 0, 1'b0);
        do_txn(3'b000, 1'b1, 1'b0, 1, 1, 4'b1000, 2, 1'b1);
        do_txn(3'b000, 1'b1, 1'b0, 0, 1, 4'b0000, 0, 1'b0);

        for (int n = 0; n < 400; n++) begin
            logic [2:0]  w;
            logic        r;
            logic        u;
            logic [3:0]  f;
            int unsigned fw;
            w  = 3'($urandom_range(0, 7));
            r  = 1'($urandom_range(0, 1));
            u  = ($urandom_range(0, 3) == 0);
            if (w == 3'b000 && !r) w = 3'b100;
            f  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
            fw = $urandom_range(0, 2);
            do_txn(w, r, u, $urandom_range(0, 3), $urandom_range(0, 3), f, fw, ($urandom_range(0, 5) == 0));
        end

        do_txn(3'b001, 1'b0, 1'b0, 0, 0, 4'b0000, 0, 1'b0);
        do_txn(3'b001, 1'b0, 1'b0, 0, 0, 4'b0000, 0, 1'b0);
        wr_req = 3'b001;
        e.id   = 2'd0;
        e.wr   = 1'b1;
        e.addr = model_addr(0);
        q.push_back(e);
        m_last = 0;
        cyc    = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!bus.cmd_valid && cyc < 8);
        wr_req = 3'b000;
        bus.cmd_ready = 1'b1;
        @(posedge clk); #1;
        bus.cmd_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_outs_zero("async_reset_outputs");
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_txn(3'b001, 1'b0, 1'b0, 0, 1, 4'b0000, 0, 1'b0);
        do_txn(3'b111, 1'b1, 1'b0, 0, 1, 4'b0000, 0, 1'b0);

        repeat (5) @(posedge clk);
        #1;
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: %0d commands outstanding, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
